// File: rtl/fft_peak_picker_if.sv
// Bin stream into the peak picker and peak index/phase result out of it.
// A bin is consumed on every rising clk edge where xk_valid is high; there is no ready, the picker never stalls the FFT.
interface fft_peak_picker_if;
    logic               xk_valid;
    logic [8:0]         xk_index;
    logic signed [15:0] xk_re;
    logic signed [15:0] xk_im;
    logic               est_done;
    logic [8:0]         max_index;
    logic signed [31:0] max_phase;
    logic               start;
    logic               busy;
    logic               frame_drop;
    logic [1:0]         dbg_state;

    modport master (
        output xk_valid, xk_index, xk_re, xk_im, est_done,
        input  max_index, max_phase, start, busy, frame_drop, dbg_state
    );

    modport slave (
        input  xk_valid, xk_index, xk_re, xk_im, est_done,
        output max_index, max_phase, start, busy, frame_drop, dbg_state
    );
endinterface

// File: rtl/fft_peak_picker.sv
// Finds the strongest positive-frequency FFT bin of a frame and its phase via a
// CORDIC vectoring engine, then hands the result to a downstream estimator.
module fft_peak_picker #(
    parameter int N_FFT  = 512,
    parameter int N_ITER = 16
) (
    input logic              clk,
    input logic              rst_n,
    fft_peak_picker_if.slave bus
);
    localparam int HALF = N_FFT / 2;
    localparam int W    = 34;  // sample scaled by 2^14 keeps small vectors accurate; headroom for CORDIC gain
    localparam int IW   = $clog2(N_ITER + 1);
    localparam logic signed [31:0] PI_Q20   = 32'sd3294199;
    localparam logic [8:0]         LAST_BIN = 9'(HALF - 1);

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN      = 2'd1,
        CORDIC    = 2'd2,
        WAIT_EST  = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [32:0]         r_best_mag;
    logic [8:0]          r_best_idx;
    logic signed [15:0]  r_best_re, r_best_im;
    logic signed [W-1:0] r_x, r_y;
    logic signed [31:0]  r_z;
    logic [IW-1:0]       r_iter;
    logic                r_axis;
    logic [8:0]          r_win_idx;
    logic [8:0]          r_max_index;
    logic signed [31:0]  r_max_phase;
    logic                r_start, r_frame_drop, r_low_seen;

    logic                w_bin0, w_in_range, w_take;
    logic                w_clear, w_load, w_finish, w_drop;
    logic signed [31:0]  w_re2, w_im2;
    logic [32:0]         w_mag;
    logic signed [15:0]  w_win_re, w_win_im;
    logic [8:0]          w_win_idx;
    logic signed [W-1:0] w_re_s, w_im_s, w_sx, w_sy;
    logic signed [31:0]  w_atan, w_phase;

    function automatic logic signed [31:0] atan_q20(input int i);
        case (i)
            0:  return 32'sd823550;
            1:  return 32'sd486170;
            2:  return 32'sd256879;
            3:  return 32'sd130396;
            4:  return 32'sd65451;
            5:  return 32'sd32757;
            6:  return 32'sd16383;
            7:  return 32'sd8192;
            8:  return 32'sd4096;
            9:  return 32'sd2048;
            10: return 32'sd1024;
            11: return 32'sd512;
            12: return 32'sd256;
            13: return 32'sd128;
            14: return 32'sd64;
            15: return 32'sd32;
            default: return (i < 21) ? (32'sd1 <<< (20 - i)) : 32'sd0;
        endcase
    endfunction

    assign w_re2      = 32'(bus.xk_re) * 32'(bus.xk_re);
    assign w_im2      = 32'(bus.xk_im) * 32'(bus.xk_im);
    assign w_mag      = {1'b0, w_re2} + {1'b0, w_im2};
    assign w_bin0     = bus.xk_valid && (bus.xk_index == 9'd0);
    assign w_in_range = bus.xk_valid && (bus.xk_index != 9'd0) && (bus.xk_index <= LAST_BIN);
    assign w_take     = w_in_range && (w_mag > r_best_mag);

    // Winner including the bin being accepted this cycle, so the last bin can still win.
    assign w_win_re  = w_take ? bus.xk_re    : r_best_re;
    assign w_win_im  = w_take ? bus.xk_im    : r_best_im;
    assign w_win_idx = w_take ? bus.xk_index : r_best_idx;
    assign w_re_s    = {{(W-30){w_win_re[15]}}, w_win_re, 14'd0};
    assign w_im_s    = {{(W-30){w_win_im[15]}}, w_win_im, 14'd0};

    assign w_sx   = r_x >>> r_iter;
    assign w_sy   = r_y >>> r_iter;
    assign w_atan = atan_q20(int'(r_iter));

    always_comb begin
        w_phase = r_z;
        if (r_z > PI_Q20)
            w_phase = PI_Q20;
        else if (r_z <= -PI_Q20)
            w_phase = -PI_Q20 + 32'sd1;
    end

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_load   = 1'b0;
        w_finish = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            SCAN_IDLE: begin
                if (w_bin0) begin
                    w_next  = SCAN;
                    w_clear = 1'b1;
                end
            end
            SCAN: begin
                if (w_bin0) begin
                    w_clear = 1'b1;
                end else if (bus.xk_valid && (bus.xk_index == LAST_BIN)) begin
                    w_load = 1'b1;
                    w_next = CORDIC;
                end
            end
            CORDIC: begin
                w_drop = w_bin0;
                if (r_iter == IW'(N_ITER)) begin
                    w_finish = 1'b1;
                    w_next   = WAIT_EST;
                end
            end
            WAIT_EST: begin
                w_drop = w_bin0;
                if (bus.est_done && r_low_seen)
                    w_next = SCAN_IDLE;
            end
            default: w_next = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_mag   <= '0;
            r_best_idx   <= 9'd1;
            r_best_re    <= '0;
            r_best_im    <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_iter       <= '0;
            r_axis       <= 1'b0;
            r_win_idx    <= '0;
            r_max_index  <= '0;
            r_max_phase  <= '0;
            r_start      <= 1'b0;
            r_frame_drop <= 1'b0;
            r_low_seen   <= 1'b0;
        end else begin
            r_start      <= w_finish;
            r_frame_drop <= w_drop;

            if (w_clear) begin
                r_best_mag <= '0;
                r_best_idx <= 9'd1;
                r_best_re  <= '0;
                r_best_im  <= '0;
            end else if ((r_state == SCAN) && w_take) begin
                r_best_mag <= w_mag;
                r_best_idx <= bus.xk_index;
                r_best_re  <= bus.xk_re;
                r_best_im  <= bus.xk_im;
            end

            // Left half-plane vectors are flipped by pi so vectoring always converges.
            if (w_load) begin
                r_x       <= w_win_re[15] ? -w_re_s : w_re_s;
                r_y       <= w_win_re[15] ? -w_im_s : w_im_s;
                r_z       <= !w_win_re[15] ? 32'sd0 : (w_win_im[15] ? -PI_Q20 : PI_Q20);
                r_axis    <= (w_win_im == 16'sd0);
                r_iter    <= '0;
                r_win_idx <= w_win_idx;
            end else if ((r_state == CORDIC) && !w_finish) begin
                r_iter <= r_iter + IW'(1);
                // On the real axis the pre-rotation angle is already exact.
                if (!r_axis) begin
                    if (r_y[W-1]) begin
                        r_x <= r_x - w_sy;
                        r_y <= r_y + w_sx;
                        r_z <= r_z - w_atan;
                    end else begin
                        r_x <= r_x + w_sy;
                        r_y <= r_y - w_sx;
                        r_z <= r_z + w_atan;
                    end
                end
            end

            if (w_finish) begin
                r_max_index <= r_win_idx;
                r_max_phase <= w_phase;
            end

            if (w_finish)
                r_low_seen <= 1'b0;
            else if ((r_state == WAIT_EST) && !bus.est_done)
                r_low_seen <= 1'b1;
        end
    end

    assign bus.max_index  = r_max_index;
    assign bus.max_phase  = r_max_phase;
    assign bus.start      = r_start;
    assign bus.frame_drop = r_frame_drop;
    assign bus.busy       = (r_state == CORDIC) || (r_state == WAIT_EST);
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_fft_peak_picker.sv
// Directed and randomized frames for fft_peak_picker, checked against an atan2-based model.
module tb_fft_peak_picker;
  localparam int N_FFT   = 512;
  localparam int N_ITER  = 16;
  localparam int HALF    = N_FFT / 2;
  localparam int TOL     = 128;
  localparam int LATENCY = N_ITER + 1;

  logic clk;
  logic rst_n;
  fft_peak_picker_if bus ();

  fft_peak_picker #(.N_FFT(N_FFT), .N_ITER(N_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int drop_cnt = 0;
  int fre [HALF];
  int fim [HALF];
  logic [40:0] exp_q [$];

  always @(negedge clk) if (rst_n && bus.frame_drop) drop_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint exp);
    longint d;
    d = (obs > exp) ? obs - exp : exp - obs;
    tests_run++;
    assert ((d <= TOL) === 1'b1) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, TOL);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < HALF; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  // reference model: strongest bin in 1..HALF-1, lowest index on ties, phase from atan2
  task automatic model_push();
    longint best, m;
    int idx, ph_i;
    real ph;
    best = 0;
    idx = 1;
    for (int i = 1; i < HALF; i++) begin
      m = longint'(fre[i]) * fre[i] + longint'(fim[i]) * fim[i];
      if (m > best) begin
        best = m;
        idx = i;
      end
    end
    if (fre[idx] == 0 && fim[idx] == 0) ph = 0.0;
    else ph = $atan2(real'(fim[idx]), real'(fre[idx])) * 1048576.0;
    ph_i = $rtoi(ph >= 0.0 ? ph + 0.5 : ph - 0.5);
    exp_q.push_back({9'(idx), 32'(ph_i)});
  endtask

  // driver tasks
  task automatic send_bin(input int idx, input int re, input int im, input bit allow_gap);
    bus.xk_valid = 1'b1;
    bus.xk_index = 9'(idx);
    bus.xk_re    = 16'(re);
    bus.xk_im    = 16'(im);
    tick();
    bus.xk_valid = 1'b0;
    if (allow_gap && $urandom_range(0, 3) == 0) tick();
  endtask

  task automatic send_frame(input int stray);
    model_push();
    for (int i = 0; i < HALF; i++) begin
      if (i == stray) send_bin(HALF + 100, 32767, -32768, 1'b1);
      send_bin(i, fre[i], fim[i], i != HALF - 1);
    end
  endtask

  task automatic wait_result(input string tag);
    int n;
    bit got, busy_ok;
    logic [40:0] e;
    logic [8:0] idx_seen;
    logic signed [31:0] ph_seen;
    n = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && n < 4 * LATENCY) begin
      tick();
      n++;
      if (bus.start) got = 1'b1;
      if (!bus.busy) busy_ok = 1'b0;
    end
    e = exp_q.pop_front();
    check_eq({tag, " start"}, got, 1);
    check_eq({tag, " latency"}, n, LATENCY);
    check_eq({tag, " busy"}, busy_ok, 1);
    check_eq({tag, " index"}, bus.max_index, e[40:32]);
    check_near({tag, " phase"}, bus.max_phase, $signed(e[31:0]));
    idx_seen = bus.max_index;
    ph_seen = bus.max_phase;
    tick();
    check_eq({tag, " start width"}, bus.start, 0);
    check_eq({tag, " hold"}, {bus.max_index, bus.max_phase}, {idx_seen, ph_seen});
  endtask

  task automatic release_est(input string tag);
    repeat (5) tick();
    check_eq({tag, " wait_est hold"}, bus.busy, 1);
    bus.est_done = 1'b0;
    tick();
    tick();
    bus.est_done = 1'b1;
    tick();
    check_eq({tag, " back to idle"}, bus.busy, 0);
  endtask

  initial begin
    logic [8:0] s_idx;
    logic signed [31:0] s_ph;
    bit saw;
    rst_n = 1'b1;
    bus.xk_valid = 1'b0;
    bus.xk_index = '0;
    bus.xk_re = '0;
    bus.xk_im = '0;
    bus.est_done = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    check_eq("reset max_index", bus.max_index, 0);
    check_eq("reset max_phase", bus.max_phase, 0);
    check_eq("reset start", bus.start, 0);
    check_eq("reset busy", bus.busy, 0);
    check_eq("reset frame_drop", bus.frame_drop, 0);
    check_eq("reset state", bus.dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // stray non-zero bins in idle are ignored, bin 0 never wins
    send_bin(5, 20000, 20000, 1'b0);
    send_bin(7, -20000, 5, 1'b0);
    clear_frame();
    fre[0] = 30000;
    fre[10] = 1000;
    send_frame(-1);
    wait_result("bin10");
    release_est("bin10");

    clear_frame();
    fim[37] = -500;
    send_frame(-1);
    wait_result("bin37");
    release_est("bin37");

    clear_frame();
    fre[5] = -300;
    send_frame(-1);
    wait_result("neg_real");
    check_eq("neg_real sign", bus.max_phase > 0, 1);
    release_est("neg_real");

    clear_frame();
    fre[20] = 100; fim[20] = 100;
    fre[40] = 100; fim[40] = 100;
    send_frame(-1);
    wait_result("tie");
    release_est("tie");

    clear_frame();
    send_frame(-1);
    wait_result("zero");
    release_est("zero");

    // frame start while waiting on the estimator is dropped
    clear_frame();
    fre[99] = -1234; fim[99] = 777;
    send_frame(-1);
    wait_result("drop");
    bus.est_done = 1'b0;
    tick();
    s_idx = bus.max_index;
    s_ph = bus.max_phase;
    bus.xk_valid = 1'b1;
    bus.xk_index = 9'd0;
    bus.xk_re = 16'sd1234;
    bus.xk_im = 16'sd0;
    tick();
    bus.xk_valid = 1'b0;
    check_eq("drop pulse", bus.frame_drop, 1);
    tick();
    check_eq("drop pulse width", bus.frame_drop, 0);
    check_eq("drop outputs", {bus.max_index, bus.max_phase}, {s_idx, s_ph});
    check_eq("drop busy", bus.busy, 1);
    bus.est_done = 1'b1;
    tick();
    check_eq("drop release", bus.busy, 0);

    for (int f = 0; f < 6; f++) begin
      clear_frame();
      for (int i = 0; i < HALF; i++) begin
        if ($urandom_range(0, f) == 0) begin
          fre[i] = rnd16();
          fim[i] = rnd16();
        end
      end
      if (f == 2) begin
        // abandoned partial frame with a huge peak; the next bin 0 restarts the search
        send_bin(0, 0, 0, 1'b1);
        for (int i = 1; i < 40; i++) send_bin(i, (i == 30) ? 32767 : 0, (i == 30) ? 32767 : 0, 1'b1);
      end
      send_frame((f == 3) ? 100 : -1);
      wait_result($sformatf("rand%0d", f));
      release_est($sformatf("rand%0d", f));
    end

    // reset five cycles into CORDIC aborts the result
    clear_frame();
    fre[50] = 500; fim[50] = -900;
    send_frame(-1);
    void'(exp_q.pop_front());
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("abort max_index", bus.max_index, 0);
    check_eq("abort max_phase", bus.max_phase, 0);
    check_eq("abort busy", bus.busy, 0);
    check_eq("abort start", bus.start, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (bus.start) saw = 1'b1;
    end
    check_eq("abort no start", saw, 0);
    check_eq("abort state", bus.dbg_state, 0);

    // bin 0 in the first cycle after release starts a frame
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_frame();
    fre[200] = -7000; fim[200] = -3000;
    send_frame(-1);
    wait_result("post_reset");
    release_est("post_reset");

    check_eq("drop count", drop_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fft_peak_picker.md
FFT_PEAK_PICKER -- requirements
Module: fft_peak_picker

Interface
REQ-001 SHALL have parameter N_FFT, default 512, FFT length; searched bins 1..N_FFT/2-1.
REQ-002 SHALL have parameter N_ITER, default 16, CORDIC vectoring iterations.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port xk_valid  input  1  FFT output bin valid this cycle.
REQ-006 SHALL have port xk_index  input  9  bin index of current sample, 0..N_FFT-1, natural order.
REQ-007 SHALL have port xk_re  input  16  signed real part.
REQ-008 SHALL have port xk_im  input  16  signed imaginary part.
REQ-009 SHALL have port est_done  input  1  downstream frequency estimator idle flag.
REQ-010 SHALL have port max_index  output  9  bin of largest magnitude in last processed frame.
REQ-011 SHALL have port max_phase  output  32  signed phase of that bin, radians, 11Q32 (1 sign, 11 integer, 20 fractional bits).
REQ-012 SHALL have port start  output  1  one-cycle pulse: max_index/max_phase valid, estimator may begin.
REQ-013 SHALL have port busy  output  1  high in CORDIC and WAIT_EST states.
REQ-014 SHALL have port frame_drop  output  1  one-cycle pulse when a frame start is ignored.

Function
REQ-015 SHALL implement states SCAN_IDLE, SCAN, CORDIC, WAIT_EST.
REQ-016 SCAN_IDLE: on xk_valid with xk_index==0 SHALL go to SCAN and clear running max (mag 0, index 1, re 0, im 0).
REQ-017 SCAN: SHALL compute mag = re^2+im^2 as 33-bit unsigned, exact, no truncation.
REQ-018 SCAN: SHALL consider only bins with index 1..N_FFT/2-1; bin 0 and upper half SHALL never win.
REQ-019 SCAN: candidate SHALL replace running max only if mag strictly greater; ties keep lower index.
REQ-020 SCAN: a new index-0 bin SHALL restart the search (clear running max, stay in SCAN).
REQ-021 SCAN: on accepting bin N_FFT/2-1 (cycle 0) SHALL latch winner re/im/index, go to CORDIC.
REQ-022 CORDIC: pre-rotation -- if re<0, negate x and y, z0 = +pi if im>=0 else -pi; else z0 = 0.
REQ-023 CORDIC: N_ITER shift-add iterations, one per cycle (cycles 1..N_ITER), arctan(2^-i) ROM in Q20, x/y datapath at least 20 bits with sign extension.
REQ-024 CORDIC: result range (-pi, +pi]; re=im=0 SHALL give phase 0; re<0, im=0 SHALL give +pi.
REQ-025 Accuracy: |max_phase - atan2(im,re)*2^20| <= 128 LSB for N_ITER=16.
REQ-026 In cycle N_ITER+1 (17 by default) max_index, max_phase SHALL update and start SHALL be high for exactly one cycle; state -> WAIT_EST.
REQ-027 max_index and max_phase SHALL hold stable from start until the next start pulse.
REQ-028 WAIT_EST: SHALL return to SCAN_IDLE on first cycle est_done is high after having been seen low at least once since start; est_done never dropping SHALL hold WAIT_EST.
REQ-029 In CORDIC or WAIT_EST, xk_valid with xk_index==0 SHALL pulse frame_drop next cycle; all bin data ignored.
REQ-030 Bins arriving in SCAN_IDLE with index != 0 SHALL be ignored silently.
REQ-031 xk_valid low SHALL freeze search; gaps between bins allowed.

Reset
REQ-032 rst_n low SHALL immediately force state SCAN_IDLE, max_index 0, max_phase 0, start 0, busy 0, frame_drop 0, running max cleared.
REQ-033 Reset mid-CORDIC or mid-WAIT_EST SHALL abort; no start pulse SHALL follow reset release until a full new frame completes.
REQ-034 First cycle after rst_n release SHALL accept an index-0 bin.

Verification
REQ-035 Frame, bin 0 re=30000, bin 10 re=1000 im=0, rest 0 -> max_index=10, max_phase=0 +/-128, start exactly 17 cycles after bin 255 accepted.
REQ-036 Bin 37 re=0 im=-500, rest 0 -> max_index=37, max_phase=-1647099 +/-128, busy high 17 cycles then through WAIT_EST.
REQ-037 Bin 5 re=-300 im=0 -> max_phase=+3294199 +/-128 (never negative pi).
REQ-038 Bins 20 and 40 both re=im=100 -> max_index=20, max_phase=823550 +/-128; all-zero frame -> max_index=1, max_phase=0.
REQ-039 Index-0 bin during WAIT_EST with est_done held low -> frame_drop one pulse, outputs unchanged; est_done low->high -> SCAN_IDLE, next frame processed.
REQ-040 rst_n low 5 cycles into CORDIC -> outputs 0 at once, no start pulse; full frame after release -> normal start.
